// File: rtl/rr_arb.sv
// Registered round-robin arbiter: one-hot grant held until acked, priority
// rotates past the last acknowledged winner; binary index via enc.

// One-hot to binary index encoder; a zero input yields index 0.
module enc #(
    parameter int W = 4
) (
    input  logic [W-1:0]         onehot,
    output logic [$clog2(W)-1:0] idx
);
    localparam int IW = $clog2(W);

    always_comb begin
        idx = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot[i]) idx = idx | IW'(i);
        end
    end
endmodule

// Handshake: a grant is presented while gnt_vld_o is high and transfers on any
// cycle with gnt_vld_o && ack_i; gnt_o/gnt_enc_o are stable until that cycle.
module rr_arb #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    input  logic                 ack_i,
    output logic                 gnt_vld_o,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_enc_o,
    output logic                 dbg_state,
    output logic [$clog2(N)-1:0] dbg_ptr
);
    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] next_ptr;

    // First requester at or after 'start', wrapping N-1 -> 0.
    function automatic logic [N-1:0] pick(input logic [N-1:0] req,
                                          input logic [PW-1:0] start);
        logic [N-1:0] win;
        logic         found;
        int           idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return win;
    endfunction

    enc #(.W(N)) u_enc (
        .onehot (gnt_o),
        .idx    (gnt_idx)
    );

    assign next_ptr  = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    assign gnt_enc_o = gnt_vld_o ? gnt_idx : '0;
    assign dbg_state = (state == GRANT);
    assign dbg_ptr   = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_o     <= '0;
            gnt_vld_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_o     <= pick(req_i, ptr);
                        gnt_vld_o <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Re-arbitrate from the advanced pointer so the served
                    // requester is last in line unless it is alone.
                    if (ack_i) begin
                        ptr       <= next_ptr;
                        gnt_o     <= pick(req_i, next_ptr);
                        gnt_vld_o <= |req_i;
                        state     <= (|req_i) ? GRANT : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_o     <= '0;
                    gnt_vld_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
